// File: rtl/eth_ipv4_extractor.sv
// Ethernet II receive deframer: filters on destination MAC / EtherType and forwards IPv4 payload bytes.
// Build option: define ETH_VLAN_STRIP_EN to strip a single 802.1Q tag before the EtherType decision.
module eth_ipv4_extractor #(
    parameter logic [47:0] MAC_ADDR         = 48'h02_00_00_00_00_01,
    parameter bit          ACCEPT_BROADCAST = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_sof_i,
    input  logic        rx_eof_i,
    output logic [7:0]  data_out_o,
    output logic        data_valid_o,
    output logic        data_last_o,
    output logic [47:0] dst_mac_o,
    output logic [47:0] src_mac_o,
    output logic [15:0] ethertype_o,
    output logic        frame_accepted_o,
    output logic        frame_dropped_o,
    output logic [15:0] drop_count_o
);

`ifdef ETH_VLAN_STRIP_EN
    typedef enum logic [2:0] {S_IDLE, S_DST, S_SRC, S_ETYPE, S_VLAN, S_PAYLOAD, S_DISCARD} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_DST, S_SRC, S_ETYPE, S_PAYLOAD, S_DISCARD} state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic        data_last_q, data_last_d;
    logic [47:0] dst_q, dst_d;
    logic [47:0] src_q, src_d;
    logic [15:0] et_q, et_d;
    logic        acc_q, acc_d;
    logic        drop_q, drop_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic [15:0] et_new;
    logic        mac_ok;
    logic        hdr_done;

    assign et_new = {et_q[7:0], rx_data_i};
    assign mac_ok = (dst_q == MAC_ADDR) || (ACCEPT_BROADCAST && (dst_q == 48'hFFFF_FFFF_FFFF));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            data_out_q   <= 8'd0;
            data_valid_q <= 1'b0;
            data_last_q  <= 1'b0;
            dst_q        <= 48'd0;
            src_q        <= 48'd0;
            et_q         <= 16'd0;
            acc_q        <= 1'b0;
            drop_q       <= 1'b0;
            drop_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            data_last_q  <= data_last_d;
            dst_q        <= dst_d;
            src_q        <= src_d;
            et_q         <= et_d;
            acc_q        <= acc_d;
            drop_q       <= drop_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Next state. An sof byte always restarts parsing; eof before the decision makes a runt.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = 1'b0;
        drop_d   = 1'b0;
        hdr_done = 1'b0;
        if (rx_valid_i) begin
            if (rx_sof_i) begin
                drop_d  = ((state_q != S_IDLE) && (state_q != S_DISCARD)) || rx_eof_i;
                state_d = rx_eof_i ? S_IDLE : S_DST;
                cnt_d   = rx_eof_i ? 4'd0 : 4'd1;
            end else begin
                case (state_q)
                    S_DST, S_SRC: begin
                        if (rx_eof_i) begin
                            drop_d  = 1'b1;
                            state_d = S_IDLE;
                            cnt_d   = 4'd0;
                        end else if (cnt_q == 4'd5) begin
                            state_d = (state_q == S_DST) ? S_SRC : S_ETYPE;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                    S_ETYPE: begin
                        if (rx_eof_i) begin
                            drop_d  = 1'b1;
                            state_d = S_IDLE;
                            cnt_d   = 4'd0;
                        end else if (cnt_q == 4'd0) begin
                            cnt_d = 4'd1;
`ifdef ETH_VLAN_STRIP_EN
                        end else if (et_new == 16'h8100) begin
                            state_d = S_VLAN;
                            cnt_d   = 4'd0;
`endif
                        end else begin
                            hdr_done = 1'b1;
                        end
                    end
`ifdef ETH_VLAN_STRIP_EN
                    S_VLAN: begin
                        if (rx_eof_i) begin
                            drop_d  = 1'b1;
                            state_d = S_IDLE;
                            cnt_d   = 4'd0;
                        end else if (cnt_q == 4'd3) begin
                            hdr_done = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
`endif
                    S_PAYLOAD, S_DISCARD: begin
                        if (rx_eof_i) begin
                            state_d = S_IDLE;
                            cnt_d   = 4'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (hdr_done) begin
            cnt_d = 4'd0;
            if (mac_ok && (et_new == 16'h0800)) begin
                acc_d   = 1'b1;
                state_d = S_PAYLOAD;
            end else begin
                drop_d  = 1'b1;
                state_d = S_DISCARD;
            end
        end
    end

    // Datapath: header shift-in, payload forwarding and the saturating drop counter.
    always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        data_last_d  = 1'b0;
        dst_d        = dst_q;
        src_d        = src_q;
        et_d         = et_q;
        drop_cnt_d   = drop_cnt_q;
        if (drop_d && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;
        if (rx_valid_i) begin
            if (rx_sof_i) begin
                dst_d = {dst_q[39:0], rx_data_i};
            end else begin
                case (state_q)
                    S_DST:   dst_d = {dst_q[39:0], rx_data_i};
                    S_SRC:   src_d = {src_q[39:0], rx_data_i};
                    S_ETYPE: et_d  = et_new;
`ifdef ETH_VLAN_STRIP_EN
                    S_VLAN:  if (cnt_q[1]) et_d = et_new;
`endif
                    S_PAYLOAD: begin
                        data_out_d   = rx_data_i;
                        data_valid_d = 1'b1;
                        data_last_d  = rx_eof_i;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_out_o       = data_out_q;
    assign data_valid_o     = data_valid_q;
    assign data_last_o      = data_last_q;
    assign dst_mac_o        = dst_q;
    assign src_mac_o        = src_q;
    assign ethertype_o      = et_q;
    assign frame_accepted_o = acc_q;
    assign frame_dropped_o  = drop_q;
    assign drop_count_o     = drop_cnt_q;

endmodule

// File: tb/tb_eth_ipv4_extractor.sv
// Directed bench for eth_ipv4_extractor; a second instance with broadcast disabled shares the stimulus.
module tb_eth_ipv4_extractor;
    localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SRC = 48'h0A_0B_0C_0D_0E_0F;
    localparam logic [47:0] BC  = 48'hFF_FF_FF_FF_FF_FF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0;

    logic [7:0]  data_out, nb_data_out;
    logic        data_valid, data_last, nb_data_valid, nb_data_last;
    logic [47:0] dst_mac, src_mac, nb_dst_mac, nb_src_mac;
    logic [15:0] ethertype, nb_ethertype, drop_count, nb_drop_count;
    logic        frame_accepted, frame_dropped, nb_frame_accepted, nb_frame_dropped;

    eth_ipv4_extractor dut (
        .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_sof_i(rx_sof), .rx_eof_i(rx_eof), .data_out_o(data_out),
        .data_valid_o(data_valid), .data_last_o(data_last), .dst_mac_o(dst_mac),
        .src_mac_o(src_mac), .ethertype_o(ethertype), .frame_accepted_o(frame_accepted),
        .frame_dropped_o(frame_dropped), .drop_count_o(drop_count));

    eth_ipv4_extractor #(.ACCEPT_BROADCAST(1'b0)) dut_nb (
        .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_sof_i(rx_sof), .rx_eof_i(rx_eof), .data_out_o(nb_data_out),
        .data_valid_o(nb_data_valid), .data_last_o(nb_data_last), .dst_mac_o(nb_dst_mac),
        .src_mac_o(nb_src_mac), .ethertype_o(nb_ethertype), .frame_accepted_o(nb_frame_accepted),
        .frame_dropped_o(nb_frame_dropped), .drop_count_o(nb_drop_count));

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int acc_n = 0, drop_n = 0, fwd_n = 0, last_n = 0, nb_dv_n = 0;
    logic [7:0] fq[$];

    always @(negedge clk) begin
        acc_n   += int'(frame_accepted);
        drop_n  += int'(frame_dropped);
        fwd_n   += int'(data_valid);
        last_n  += int'(data_last);
        nb_dv_n += int'(nb_data_valid);
    end

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One input cycle; outputs are checked 1 time unit after the sampling edge.
    task automatic send(input logic [7:0] d, input bit v, input bit sof, input bit eof,
                        input bit fwd, input bit lst);
        @(negedge clk);
        rx_data = d; rx_valid = v; rx_sof = sof; rx_eof = eof;
        @(posedge clk);
        #1;
        chk("dvalid", data_valid, fwd);
        chk("dlast", data_last, lst);
        if (fwd) chk("dout", data_out, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push48(input logic [47:0] x);
        for (int i = 5; i >= 0; i--) fq.push_back(x[8*i +: 8]);
    endtask

    task automatic push16(input logic [15:0] x);
        fq.push_back(x[15:8]);
        fq.push_back(x[7:0]);
    endtask

    task automatic push_pay(input int n);
        for (int i = 0; i < n; i++)
            fq.push_back(i == 0 ? 8'h45 : (i == 1 ? 8'h00 : 8'(i)));
    endtask

    task automatic build(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et, input int npay);
        fq.delete();
        push48(d); push48(s); push16(et); push_pay(npay);
    endtask

    task automatic send_q(input int hdr, input bit acc, input bit gap, input bit eof_end);
        for (int i = 0; i < fq.size(); i++) begin
            bit f, e;
            f = acc && (i >= hdr);
            e = eof_end && (i == fq.size() - 1);
            send(fq[i], 1'b1, i == 0, e, f, f && e);
            if (gap) send(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout"}, data_out, 0);
        chk({tag, "_dv"}, data_valid, 0);
        chk({tag, "_dl"}, data_last, 0);
        chk({tag, "_dst"}, dst_mac, 0);
        chk({tag, "_src"}, src_mac, 0);
        chk({tag, "_et"}, ethertype, 0);
        chk({tag, "_acc"}, frame_accepted, 0);
        chk({tag, "_drp"}, frame_dropped, 0);
        chk({tag, "_cnt"}, drop_count, 0);
    endtask

    initial begin
        int a0, d0, f0, l0, n0;

        do_reset();
        chk_zero("rst");
        chk("rst_nbcnt", nb_drop_count, 0);

        // Unicast IPv4, 20 payload bytes
        a0 = acc_n; f0 = fwd_n; l0 = last_n;
        build(MAC, SRC, 16'h0800, 20);
        send_q(14, 1'b1, 1'b0, 1'b1);
        idle(2);
        chk("uc_acc", acc_n - a0, 1);
        chk("uc_fwd", fwd_n - f0, 20);
        chk("uc_last", last_n - l0, 1);
        chk("uc_cnt", drop_count, 0);
        chk("uc_dst", dst_mac, MAC);
        chk("uc_src", src_mac, SRC);
        chk("uc_et", ethertype, 16'h0800);

        // Filter drops: ARP, foreign unicast, broadcast (accepted only when enabled)
        d0 = drop_n; n0 = nb_dv_n; f0 = fwd_n;
        build(MAC, SRC, 16'h0806, 4);
        send_q(14, 1'b0, 1'b0, 1'b1);
        chk("arp_et", ethertype, 16'h0806);
        build(48'h02_00_00_00_00_02, SRC, 16'h0800, 4);
        send_q(14, 1'b0, 1'b0, 1'b1);
        build(BC, SRC, 16'h0800, 4);
        send_q(14, 1'b1, 1'b0, 1'b1);
        idle(2);
        chk("flt_drops", drop_n - d0, 2);
        chk("flt_cnt", drop_count, 2);
        chk("flt_bcfwd", fwd_n - f0, 4);
        chk("flt_nbcnt", nb_drop_count, 3);
        chk("flt_nbdv", nb_dv_n - n0, 0);

        // Runt, truncated header, aborted payload, then a clean frame
        do_reset();
        a0 = acc_n; f0 = fwd_n; l0 = last_n;
        send(8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        build(MAC, SRC, 16'h0800, 0);
        while (fq.size() > 10) void'(fq.pop_back());
        send_q(14, 1'b0, 1'b0, 1'b1);
        build(MAC, SRC, 16'h0800, 5);
        send_q(14, 1'b1, 1'b0, 1'b0);
        chk("abt_last", last_n - l0, 0);
        build(MAC, 48'h11_22_33_44_55_66, 16'h0800, 3);
        send_q(14, 1'b1, 1'b0, 1'b1);
        idle(2);
        chk("abt_cnt", drop_count, 3);
        chk("abt_fwd", fwd_n - f0, 8);
        chk("abt_last2", last_n - l0, 1);
        chk("abt_acc", acc_n - a0, 2);
        chk("abt_src", src_mac, 48'h11_22_33_44_55_66);

        // Gapped input
        a0 = acc_n;
        build(MAC, 48'hA1_B2_C3_D4_E5_F6, 16'h0800, 6);
        send_q(14, 1'b1, 1'b1, 1'b1);
        chk("gap_acc", acc_n - a0, 1);
        chk("gap_dst", dst_mac, MAC);
        chk("gap_src", src_mac, 48'hA1_B2_C3_D4_E5_F6);
        chk("gap_et", ethertype, 16'h0800);

        // VLAN-tagged IPv4
        a0 = acc_n; d0 = drop_n; f0 = fwd_n;
        build(MAC, SRC, 16'h8100, 0);
        push16(16'h0005); push16(16'h0800); push_pay(8);
`ifdef ETH_VLAN_STRIP_EN
        send_q(18, 1'b1, 1'b0, 1'b1);
        idle(1);
        chk("vlan_et", ethertype, 16'h0800);
        chk("vlan_fwd", fwd_n - f0, 8);
        chk("vlan_acc", acc_n - a0, 1);
`else
        send_q(18, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("vlan_et", ethertype, 16'h8100);
        chk("vlan_fwd", fwd_n - f0, 0);
        chk("vlan_drop", drop_n - d0, 1);
`endif

        // Reset in the middle of a payload
        build(MAC, SRC, 16'h0800, 7);
        for (int i = 0; i < 17; i++)
            send(fq[i], 1'b1, i == 0, 1'b0, i >= 14, 1'b0);
        do_reset();
        #1;
        chk_zero("mid");
        for (int i = 17; i < 21; i++)
            send(fq[i], 1'b1, 1'b0, i == 20, 1'b0, 1'b0);
        idle(1);
        chk("mid_cnt", drop_count, 0);
        a0 = acc_n;
        build(MAC, SRC, 16'h0800, 2);
        send_q(14, 1'b1, 1'b0, 1'b1);
        chk("mid_acc", acc_n - a0, 1);

        // Drop counter saturation
        do_reset();
        @(negedge clk);
        rx_valid = 1'b1; rx_sof = 1'b1; rx_eof = 1'b1; rx_data = 8'h00;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
        chk("sat_fffe", drop_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) send(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("sat_ffff", drop_count, 16'hFFFF);
        chk("sat_nb", nb_drop_count, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
